ecc_reg_bank: RTL

- Register bank directly downstream of the APB slave.
- Consumes the slave's REG_ENABLE qualifier together with the APB address, data and direction lines, and holds the ECC configuration registers.
- Issues a one-cycle start pulse to the ECC core and tracks core busy/done.
- Provides read-back data and a status register to the bus.

---
 rtl/ecc_reg_bank.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ecc_reg_bank.sv
// rtl/ecc_reg_bank.sv - ECC configuration register bank with start/busy tracking
// Decodes APB accesses into four config registers, a status register and a core handshake.
module ecc_reg_bank #(
  parameter int AMBA_WORD       = 16,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       REG_ENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic [1:0]                 CTRL,
  output logic [DATA_WIDTH-1:0]      DATA_IN,
  output logic [1:0]                 CODEWORD_WIDTH,
  output logic [DATA_WIDTH-1:0]      NOISE,
  output logic                       start,
  input  logic                       core_done
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [2:0] SEL_CTRL   = 3'd0;
  localparam logic [2:0] SEL_DATA   = 3'd1;
  localparam logic [2:0] SEL_CWW    = 3'd2;
  localparam logic [2:0] SEL_NOISE  = 3'd3;
  localparam logic [2:0] SEL_STATUS = 3'd4;

  state_t                state_q, state_d;
  logic                  start_q, start_d;
  logic                  wr_dropped_q, wr_dropped_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic [1:0]            cww_q, cww_d;
  logic [DATA_WIDTH-1:0] noise_q, noise_d;

  logic [2:0] sel;
  logic       wr_acc;
  logic       rd_acc;
  logic       cfg_sel;
  logic       ctrl_go;
  logic       drop;
  logic       unused_bits;

  assign sel     = PADDR[4:2];
  assign wr_acc  = REG_ENABLE & PWRITE;
  assign rd_acc  = REG_ENABLE & ~PWRITE;
  assign cfg_sel = (sel <= SEL_NOISE);
  // Only an idle CTRL write with a legal opcode launches the core.
  assign ctrl_go = wr_acc && (state_q == IDLE) && (sel == SEL_CTRL) && (PWDATA[1:0] != 2'd3);
  assign drop    = wr_acc && ((state_q == BUSY && cfg_sel) ||
                              (state_q == IDLE && sel == SEL_CTRL && PWDATA[1:0] == 2'd3));
  assign unused_bits = ^{PADDR, PWDATA};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      wr_dropped_q <= 1'b0;
      ctrl_q       <= '0;
      data_in_q    <= '0;
      cww_q        <= '0;
      noise_q      <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      wr_dropped_q <= wr_dropped_d;
      ctrl_q       <= ctrl_d;
      data_in_q    <= data_in_d;
      cww_q        <= cww_d;
      noise_q      <= noise_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ctrl_go) state_d = BUSY;
      BUSY: if (core_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start_d      = ctrl_go;
    ctrl_d       = ctrl_q;
    data_in_d    = data_in_q;
    cww_d        = cww_q;
    noise_d      = noise_q;
    wr_dropped_d = wr_dropped_q;
    if (rd_acc && sel == SEL_STATUS) wr_dropped_d = 1'b0;
    // Setting must win over a same-cycle status-read clear.
    if (drop) wr_dropped_d = 1'b1;
    if (wr_acc && state_q == IDLE) begin
      case (sel)
        SEL_CTRL:  if (ctrl_go) ctrl_d = PWDATA[1:0];
        SEL_DATA:  data_in_d = PWDATA[DATA_WIDTH-1:0];
        SEL_CWW:   cww_d = PWDATA[1:0];
        SEL_NOISE: noise_d = PWDATA[DATA_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    PRDATA = '0;
    if (rd_acc) begin
      case (sel)
        SEL_CTRL:   PRDATA[1:0] = ctrl_q;
        SEL_DATA:   PRDATA[DATA_WIDTH-1:0] = data_in_q;
        SEL_CWW:    PRDATA[1:0] = cww_q;
        SEL_NOISE:  PRDATA[DATA_WIDTH-1:0] = noise_q;
        SEL_STATUS: PRDATA[1:0] = {wr_dropped_q, state_q == BUSY};
        default:    PRDATA = '0;
      endcase
    end
  end

  assign CTRL           = ctrl_q;
  assign DATA_IN        = data_in_q;
  assign CODEWORD_WIDTH = cww_q;
  assign NOISE          = noise_q;
  assign start          = start_q;

endmodule
